ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_pkg.sv | 31 +++
 rtl/ifetch_queue_fifo.sv | 75 +++++++
 rtl/ifetch_queue.sv | 142 ++++++++++++++
 tb/tb_ifetch_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction fetch queue: the queued entry layout,
// the fetch FSM state encoding and the pc-step helpers.
package ifetch_queue_pkg;

  // Fetch sequencer states: no request, request outstanding, or an
  // outstanding request whose response is to be thrown away.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } ifq_state_e;

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [63:0] INSTR_BYTES = 64'd4;

  // Sequential fetch step; wraps modulo 2^64.
  function automatic logic [63:0] next_pc(input logic [63:0] pc);
    return pc + INSTR_BYTES;
  endfunction

  // Fetch addresses are always word aligned.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Circular storage for fetched instructions: entry array, read/write
// pointers and occupancy count. clear_i empties the queue in one cycle and
// takes priority over push/pop. The caller never pushes into a full queue
// unless it pops in the same cycle.
module ifetch_queue_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  fetch_entry_t           push_entry_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Next pointer and count values; a flush resets everything to empty.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all clocked state so every
    // register samples the pre-edge value of its inputs.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  // NOTE: the array is deliberately not reset; the count and pointers
  // already say which entries hold live data.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: sequences single-outstanding ibus requests from
// a running fetch pc, buffers responses for decode, and handles redirects
// (flush + restart) including responses still in flight.
// Optional feature: define IFETCH_QUEUE_BYPASS_EN to hand a response
// straight to decode in the same cycle when the queue is empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   ireq_valid,
  output logic [63:0]            ireq_addr,
  input  logic                   iresp_data_ok,
  input  logic [31:0]            iresp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int unsigned     CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_FREE  = CNT_W'(DEPTH - 1);

  ifq_state_e   state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;  // next address to fetch / restart target
  logic [63:0]  req_addr_q, req_addr_d;  // address of the request on the bus
  logic [63:0]  target_pc;
  logic         resp_accept;
  logic         bypass_active;
  logic         queue_empty;
  logic         push;
  logic         fifo_pop;
  logic         becomes_full;
  fetch_entry_t resp_entry;
  fetch_entry_t head_entry;
  fetch_entry_t out_entry;

  assign target_pc   = align_pc(redirect_pc);
  assign queue_empty = (out_count == '0);
  assign resp_entry  = '{pc: req_addr_q, instr: iresp_data};

  // A response is kept only when it answers a live request and no
  // redirect is flushing the stream in the same cycle.
  assign resp_accept = (state_q == REQ) && iresp_data_ok && !redirect_valid;

`ifdef IFETCH_QUEUE_BYPASS_EN
  assign bypass_active = resp_accept && queue_empty;
`else
  assign bypass_active = 1'b0;
`endif

  // Redirect hides the head so nothing is consumed while the queue flushes.
  assign out_valid = (!queue_empty || bypass_active) && !redirect_valid;
  assign out_entry = bypass_active ? resp_entry : head_entry;
  assign out_pc    = out_valid ? out_entry.pc    : '0;
  assign out_instr = out_valid ? out_entry.instr : '0;

  // A bypassed response that decode takes right away never enters storage.
  assign fifo_pop     = out_valid && out_ready && !queue_empty;
  assign push         = resp_accept && !(bypass_active && out_ready);
  assign becomes_full = push && !fifo_pop && (out_count == LAST_FREE);

  assign ireq_valid = (state_q != IDLE);
  assign ireq_addr  = ireq_valid ? req_addr_q : '0;

  ifetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (redirect_valid),
    .push_i       (push),
    .pop_i        (fifo_pop),
    .push_entry_i (resp_entry),
    .head_o       (head_entry),
    .count_o      (out_count)
  );

  // Fetch sequencer: next state, next fetch pc and next bus address.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          state_d    = REQ;
          fetch_pc_d = target_pc;
          req_addr_d = target_pc;
        end else if (out_count < FULL_COUNT) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc;
          if (iresp_data_ok) begin
            // Response dropped; the bus is free, restart next cycle.
            req_addr_d = target_pc;
          end else begin
            // Old request still owns the bus; wait it out.
            state_d = DRAIN;
          end
        end else if (iresp_data_ok) begin
          fetch_pc_d = next_pc(fetch_pc_q);
          req_addr_d = next_pc(fetch_pc_q);
          if (becomes_full) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (redirect_valid) fetch_pc_d = target_pc;
        if (iresp_data_ok) begin
          state_d    = REQ;
          req_addr_d = redirect_valid ? target_pc : fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue. A driver picks stimulus each cycle
// (just after the rising edge) and keeps a transaction-level reference
// model: the outstanding request, whether its answer is to be dropped, the
// next fetch pc, and a queue of the instructions decode should receive.
// A monitor samples on the falling edge and compares the DUT against it.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             redirect_valid;
  logic [63:0]      redirect_pc;
  logic             ireq_valid;
  logic [63:0]      ireq_addr;
  logic             iresp_data_ok;
  logic [31:0]      iresp_data;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_pc;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] out_count;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      if (n_miscompares <= 40)
        $display("FAIL %s: got %h expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model state.
  bit           m_busy;      // a request is on the bus this cycle
  bit           m_drop;      // its answer will be discarded
  logic [63:0]  m_addr;      // its address
  logic [63:0]  m_next;      // pc the stream continues from
  fetch_entry_t exp_q[$];    // instructions owed to decode, oldest first

  // This cycle's stimulus as seen by the model and monitor.
  bit          cur_reset, cur_redirect, cur_dok, cur_accept;
  logic [63:0] cur_tgt;
  int          cnt_start;    // queue occupancy at the start of the cycle
  int          reset_hold;

  // Stimulus phases: cycles, response / ready / redirect / reset odds per 1000.
  localparam int NUM_PH = 6;
  int ph_cycles[NUM_PH] = '{40,   40,   40, 400, 400, 300};
  int ph_resp  [NUM_PH] = '{1000, 1000, 1000, 500, 300, 700};
  int ph_ready [NUM_PH] = '{1000, 0,    1000, 600, 500, 900};
  int ph_redir [NUM_PH] = '{0,    0,    0,   60,  100, 30};
  int ph_reset [NUM_PH] = '{0,    0,    0,   0,   10,  5};

  function automatic logic [63:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 64'h8000_1002;
      1:       return 64'hFFFF_FFFF_FFFF_FFF9;
      2:       return RESET_PC + 64'($urandom_range(0, 255));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_drop = 1'b0;
    m_addr = RESET_PC;
    m_next = RESET_PC;
    exp_q.delete();
  endtask

  // Apply the rules of the fetch protocol to the clock edge just taken.
  task automatic model_edge();
    int size_after;
    size_after = exp_q.size();
    if (cur_redirect) exp_q.delete();
    if (!m_busy) begin
      if (cur_redirect) begin
        m_busy = 1'b1;
        m_next = cur_tgt;
        m_addr = cur_tgt;
      end else if (cnt_start < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_next;
      end
    end else if (!m_drop) begin
      if (cur_redirect) begin
        m_next = cur_tgt;
        if (cur_dok) m_addr = cur_tgt;
        else         m_drop = 1'b1;
      end else if (cur_dok) begin
        m_next = m_next + 64'd4;
        if (size_after == DEPTH) m_busy = 1'b0;
        else                     m_addr = m_next;
      end
    end else begin
      if (cur_redirect) m_next = cur_tgt;
      if (cur_dok) begin
        m_drop = 1'b0;
        m_addr = m_next;
      end
    end
  endtask

  task automatic drive_quiet();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    out_ready      = 1'b0;
    cur_redirect   = 1'b0;
    cur_dok        = 1'b0;
    cur_accept     = 1'b0;
    cur_tgt        = '0;
  endtask

  task automatic drive_random(input int ph);
    logic [63:0] raw;
    logic [31:0] data;
    bit          dok, rdr;
    raw  = pick_target();
    data = $urandom();
    dok  = m_busy && ($urandom_range(0, 999) < ph_resp[ph]);
    rdr  = ($urandom_range(0, 999) < ph_redir[ph]);
    redirect_valid = rdr;
    redirect_pc    = raw;
    iresp_data_ok  = dok;
    iresp_data     = data;
    out_ready      = ($urandom_range(0, 999) < ph_ready[ph]);
    cur_redirect   = rdr;
    cur_dok        = dok;
    cur_tgt        = raw & ~64'h3;
    cur_accept     = dok && !m_drop && !rdr;
    if (cur_accept) exp_q.push_back('{pc: m_addr, instr: data});
  endtask

  // Driver and reference model.
  initial begin
    reset = 1'b0;
    drive_quiet();
    model_reset();
    cur_reset  = 1'b1;
    reset_hold = 2;
    cnt_start  = 0;
    for (int ph = 0; ph < NUM_PH; ph++) begin
      for (int c = 0; c < ph_cycles[ph]; c++) begin
        @(posedge clk);
        #1;
        if (!cur_reset) model_edge();
        cnt_start = exp_q.size();
        if (cur_reset) begin
          if (reset_hold > 0) reset_hold--;
          else begin
            reset     = 1'b1;
            cur_reset = 1'b0;
          end
          drive_quiet();
        end else if (ph_reset[ph] > 0 &&
                     (($urandom_range(0, 999) < ph_reset[ph]) ||
                      (m_drop && $urandom_range(0, 3) == 0))) begin
          reset = 1'b0;
          model_reset();
          cur_reset  = 1'b1;
          reset_hold = $urandom_range(0, 2);
          cnt_start  = 0;
          drive_quiet();
        end else begin
          drive_random(ph);
        end
      end
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Monitor: compare the DUT to the model mid-cycle and retire entries
  // that decode takes.
  initial begin
    int  exp_count;
    bit  exp_valid;
    forever begin
      @(negedge clk);
      exp_count = exp_q.size() - (cur_accept ? 1 : 0);
      exp_valid = !cur_reset && !cur_redirect &&
                  (exp_count != 0 || (BYPASS && cur_accept));
      check("ireq_valid", 64'(ireq_valid), 64'(m_busy));
      check("ireq_addr",  ireq_addr, m_busy ? m_addr : 64'd0);
      check("out_count",  64'(out_count), 64'(exp_count));
      check("out_valid",  64'(out_valid), 64'(exp_valid));
      if (exp_valid) begin
        check("out_pc",    out_pc, exp_q[0].pc);
        check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        check("out_pc_idle",    out_pc, 64'd0);
        check("out_instr_idle", 64'(out_instr), 64'd0);
      end
    end
  end

endmodule
